// File: rtl/uart_bus_responder_pkg.sv
// ------------------------------------------------------------------
// uart_bus_responder_pkg : shared constants, FSM encodings, helpers
// Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

package uart_bus_responder_pkg;

   localparam int UART_CLK_HZ = 50_000_000;
   localparam int UART_BAUD   = 9600;

   localparam logic [1:0] UTX_IDLE  = 2'd0;
   localparam logic [1:0] UTX_START = 2'd1;
   localparam logic [1:0] UTX_DATA  = 2'd2;
   localparam logic [1:0] UTX_STOP  = 2'd3;

   localparam logic [1:0] URX_IDLE  = 2'd0;
   localparam logic [1:0] URX_START = 2'd1;
   localparam logic [1:0] URX_DATA  = 2'd2;
   localparam logic [1:0] URX_STOP  = 2'd3;

   typedef struct packed {
      logic overrun;
      logic frame_err;
   } rx_err_t;

   // Sample-tick divider: clocks per 1/16 bit, truncated
   function automatic int uart_div(input int clk_hz, input int baud);
      return clk_hz / (baud * 16);
   endfunction

endpackage

`default_nettype wire

// File: rtl/uart_rx_fifo.sv
// ------------------------------------------------------------------
// uart_rx_fifo : RX byte FIFO, power-of-two depth, same-cycle push/pop
// Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

module uart_rx_fifo #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 8
) (
   input  logic             memi_clk,
   input  logic             memi_rst,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   output logic [WIDTH-1:0] head,
   output logic             full,
   output logic             empty
);

   localparam int              c_AW      = $clog2(DEPTH);
   localparam logic [c_AW:0]   c_FULL    = (c_AW + 1)'(DEPTH);
   localparam logic [c_AW:0]   c_CNT_INC = (c_AW + 1)'(1);
   localparam logic [c_AW-1:0] c_PTR_INC = c_AW'(1);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [c_AW-1:0]  r_wr_ptr;
   logic [c_AW-1:0]  r_rd_ptr;
   logic [c_AW:0]    r_count;
   logic             w_do_push;
   logic             w_do_pop;

   assign full  = (r_count == c_FULL);
   assign empty = (r_count == '0);
   assign head  = r_mem[r_rd_ptr];

   // A pop frees the slot a simultaneous push needs, so a full FIFO still accepts it
   assign w_do_pop  = pop && !empty;
   assign w_do_push = push && (!full || w_do_pop);

   always_ff @(posedge memi_clk or negedge memi_rst) begin
      if (!memi_rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_do_push) r_wr_ptr <= r_wr_ptr + c_PTR_INC;
         if (w_do_pop)  r_rd_ptr <= r_rd_ptr + c_PTR_INC;
         case ({w_do_push, w_do_pop})
            2'b10:   r_count <= r_count + c_CNT_INC;
            2'b01:   r_count <= r_count - c_CNT_INC;
            default: r_count <= r_count;
         endcase
      end
   end

   always_ff @(posedge memi_clk) begin
      if (w_do_push) r_mem[r_wr_ptr] <= push_data;
   end

endmodule

`default_nettype wire

// File: rtl/uart_bus_responder.sv
// ------------------------------------------------------------------
// uart_bus_responder : MEM-stage UART peripheral, 8N1 TX/RX with RX FIFO
// Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

module uart_bus_responder
   import uart_bus_responder_pkg::*;
#(
   parameter int CLK_HZ   = UART_CLK_HZ,
   parameter int BAUD     = UART_BAUD,
   parameter int RX_DEPTH = 4
) (
   input  logic       memi_clk,
   input  logic       memi_rst,
   input  logic       bus_rdn,
   input  logic       bus_wrn,
   input  logic [7:0] bus_wdata,
   output logic [7:0] bus_rdata,
   output logic       data_ready,
   output logic       tbre,
   output logic       tsre,
   output logic       rx_overrun,
   output logic       rx_frame_err,
   input  logic       rxd,
   output logic       txd
);

   localparam int              c_DIV      = uart_div(CLK_HZ, BAUD);
   localparam int              c_BIT_CLKS = 16 * c_DIV;
   localparam int              c_DW       = (c_DIV > 1) ? $clog2(c_DIV) : 1;
   localparam int              c_BW       = $clog2(c_BIT_CLKS);
   localparam logic [c_DW-1:0] c_DIV_LAST = c_DW'(c_DIV - 1);
   localparam logic [c_DW-1:0] c_DIV_INC  = c_DW'(1);
   localparam logic [c_BW-1:0] c_BIT_LAST = c_BW'(c_BIT_CLKS - 1);
   localparam logic [c_BW-1:0] c_BIT_INC  = c_BW'(1);

   logic            r_wrn_q;
   logic            r_rdn_q;
   logic            w_wr_edge;
   logic            w_rd_rise;

   logic [c_DW-1:0] r_div_cnt;
   logic            w_tick;

   logic [7:0]      r_hold;
   logic            r_hold_vld;
   logic [1:0]      r_tx_state;
   logic [7:0]      r_tx_shift;
   logic [c_BW-1:0] r_tx_clk;
   logic [2:0]      r_tx_bits;
   logic            w_tx_bit_end;

   logic            r_rx_s1;
   logic            r_rx_s2;
   logic            r_rx_prev;
   logic [1:0]      r_rx_state;
   logic [3:0]      r_rx_ticks;
   logic [2:0]      r_rx_bits;
   logic [7:0]      r_rx_shift;
   logic            w_rx_mid;
   logic            w_rx_push;
   logic            w_rx_ferr;

   rx_err_t         r_err;
   logic [7:0]      w_head;
   logic            w_full;
   logic            w_empty;
   logic            w_pop;

   // ---------------- bus strobe edge detect ----------------
   always_ff @(posedge memi_clk or negedge memi_rst) begin
      if (!memi_rst) begin
         r_wrn_q <= 1'b1;
         r_rdn_q <= 1'b1;
      end else begin
         r_wrn_q <= bus_wrn;
         r_rdn_q <= bus_rdn;
      end
   end

   assign w_wr_edge = !bus_wrn && r_wrn_q;
   assign w_rd_rise = bus_rdn && !r_rdn_q;

   // ---------------- 16x sample tick ----------------
   assign w_tick = (r_div_cnt == c_DIV_LAST);

   always_ff @(posedge memi_clk or negedge memi_rst) begin
      if (!memi_rst) r_div_cnt <= '0;
      else if (w_tick) r_div_cnt <= '0;
      else r_div_cnt <= r_div_cnt + c_DIV_INC;
   end

   // ---------------- transmitter ----------------
   assign w_tx_bit_end = (r_tx_clk == c_BIT_LAST);

   always_ff @(posedge memi_clk or negedge memi_rst) begin
      if (!memi_rst) begin
         r_hold     <= '0;
         r_hold_vld <= 1'b0;
         r_tx_state <= UTX_IDLE;
         r_tx_shift <= '0;
         r_tx_clk   <= '0;
         r_tx_bits  <= '0;
      end else begin
         // Holding only loads when empty and the FSM only drains it when full
         if (w_wr_edge && !r_hold_vld) begin
            r_hold     <= bus_wdata;
            r_hold_vld <= 1'b1;
         end
         case (r_tx_state)
            UTX_IDLE: begin
               if (r_hold_vld) begin
                  r_tx_shift <= r_hold;
                  r_hold_vld <= 1'b0;
                  r_tx_clk   <= '0;
                  r_tx_bits  <= '0;
                  r_tx_state <= UTX_START;
               end
            end
            UTX_START: begin
               if (w_tx_bit_end) begin
                  r_tx_clk   <= '0;
                  r_tx_bits  <= '0;
                  r_tx_state <= UTX_DATA;
               end else begin
                  r_tx_clk <= r_tx_clk + c_BIT_INC;
               end
            end
            UTX_DATA: begin
               if (w_tx_bit_end) begin
                  r_tx_clk   <= '0;
                  r_tx_shift <= {1'b0, r_tx_shift[7:1]};
                  r_tx_bits  <= r_tx_bits + 3'd1;
                  if (r_tx_bits == 3'd7) r_tx_state <= UTX_STOP;
               end else begin
                  r_tx_clk <= r_tx_clk + c_BIT_INC;
               end
            end
            UTX_STOP: begin
               if (w_tx_bit_end) begin
                  r_tx_clk <= '0;
                  if (r_hold_vld) begin
                     r_tx_shift <= r_hold;
                     r_hold_vld <= 1'b0;
                     r_tx_bits  <= '0;
                     r_tx_state <= UTX_START;
                  end else begin
                     r_tx_state <= UTX_IDLE;
                  end
               end else begin
                  r_tx_clk <= r_tx_clk + c_BIT_INC;
               end
            end
            default: r_tx_state <= UTX_IDLE;
         endcase
      end
   end

   // Decoded from state so an asynchronous reset releases the line at once
   always_comb begin
      txd = 1'b1;
      case (r_tx_state)
         UTX_START: txd = 1'b0;
         UTX_DATA:  txd = r_tx_shift[0];
         default:   txd = 1'b1;
      endcase
   end

   assign tbre = !r_hold_vld;
   assign tsre = (r_tx_state == UTX_IDLE) && !r_hold_vld;

   // ---------------- receiver ----------------
   always_ff @(posedge memi_clk or negedge memi_rst) begin
      if (!memi_rst) begin
         r_rx_s1   <= 1'b1;
         r_rx_s2   <= 1'b1;
         r_rx_prev <= 1'b1;
      end else begin
         r_rx_s1   <= rxd;
         r_rx_s2   <= r_rx_s1;
         r_rx_prev <= r_rx_s2;
      end
   end

   assign w_rx_mid  = w_tick && (r_rx_ticks == 4'd15);
   assign w_rx_push = (r_rx_state == URX_STOP) && w_rx_mid && r_rx_s2;
   assign w_rx_ferr = (r_rx_state == URX_STOP) && w_rx_mid && !r_rx_s2;

   always_ff @(posedge memi_clk or negedge memi_rst) begin
      if (!memi_rst) begin
         r_rx_state <= URX_IDLE;
         r_rx_ticks <= '0;
         r_rx_bits  <= '0;
         r_rx_shift <= '0;
      end else begin
         case (r_rx_state)
            URX_IDLE: begin
               if (r_rx_prev && !r_rx_s2) begin
                  r_rx_ticks <= '0;
                  r_rx_state <= URX_START;
               end
            end
            URX_START: begin
               // Half a bit in: a line back high was a glitch, not a start bit
               if (w_tick) begin
                  if (r_rx_ticks == 4'd7) begin
                     r_rx_ticks <= '0;
                     r_rx_bits  <= '0;
                     r_rx_state <= r_rx_s2 ? URX_IDLE : URX_DATA;
                  end else begin
                     r_rx_ticks <= r_rx_ticks + 4'd1;
                  end
               end
            end
            URX_DATA: begin
               if (w_tick) begin
                  r_rx_ticks <= r_rx_ticks + 4'd1;
                  if (r_rx_ticks == 4'd15) begin
                     r_rx_shift <= {r_rx_s2, r_rx_shift[7:1]};
                     r_rx_bits  <= r_rx_bits + 3'd1;
                     if (r_rx_bits == 3'd7) r_rx_state <= URX_STOP;
                  end
               end
            end
            URX_STOP: begin
               if (w_tick) begin
                  r_rx_ticks <= r_rx_ticks + 4'd1;
                  if (r_rx_ticks == 4'd15) r_rx_state <= URX_IDLE;
               end
            end
            default: r_rx_state <= URX_IDLE;
         endcase
      end
   end

   // ---------------- RX FIFO and bus read side ----------------
   assign w_pop = w_rd_rise && !w_empty;

   uart_rx_fifo #(
      .DEPTH (RX_DEPTH),
      .WIDTH (8)
   ) u_rx_fifo (
      .memi_clk  (memi_clk),
      .memi_rst  (memi_rst),
      .push      (w_rx_push),
      .push_data (r_rx_shift),
      .pop       (w_pop),
      .head      (w_head),
      .full      (w_full),
      .empty     (w_empty)
   );

   // A new error in the same cycle as the clearing read survives the read
   always_ff @(posedge memi_clk or negedge memi_rst) begin
      if (!memi_rst) begin
         r_err <= '0;
      end else begin
         if (w_rd_rise) r_err <= '0;
         if (w_rx_push && w_full && !w_pop) r_err.overrun <= 1'b1;
         if (w_rx_ferr) r_err.frame_err <= 1'b1;
      end
   end

   assign bus_rdata    = (!bus_rdn && !w_empty) ? w_head : 8'h00;
   assign data_ready   = !w_empty;
   assign rx_overrun   = r_err.overrun;
   assign rx_frame_err = r_err.frame_err;

endmodule

`default_nettype wire
